uart_tx: RTL and testbench

Serial transmitter for the UART link: accepts bytes over a valid/ready handshake and shifts them out on `tx` as 8N1 frames (start, 8 data bits LSB first, stop) at a fixed baud derived from the system clock. A one-entry holding register lets the next byte be queued while the current frame is on the wire, so back-to-back frames have no idle gap. It pairs with the receiver on the same link and drives the board's UART TX pin directly.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 31 +++
 rtl/uart_baud_timer.sv | 41 ++++
 rtl/uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART transmitter and receiver:
//               default clock/baud figures, the clocks-per-bit helper and
//               the line-state encoding used by both FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_default_clk_hz = 12_000_000;
    localparam int c_default_baud   = 115_200;

    // Line states. Values are fixed so waveforms decode the same way in
    // every build, whether or not the parity stage is present.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } line_state_t;

    // Whole system-clock cycles per bit period (truncating division).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-input handshake of the UART transmitter.
//               in_data  - byte to transmit
//               in_valid - in_data is valid
//               in_ready - transmitter holding register is empty
//               A byte moves at a rising clock edge with in_valid && in_ready.
//               master : byte producer, slave : transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface : uart_tx_if
`default_nettype wire

// File: rtl/uart_baud_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_timer
// Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps;
//               bit_end is high during the last cycle of each bit period.
//               restart forces the count back to 0 at the next edge.
// Ports       : clk     in  system clock
//               rst_n   in  asynchronous active-low reset
//               restart in  clear the count (state change / idle)
//               bit_end out last cycle of the current bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 104
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic restart,
    output logic      bit_end
);

    // A one-cycle bit still needs a 1-bit counter to keep the vector legal.
    localparam int                 c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign bit_end = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : uart_baud_timer
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts bytes over a valid/ready handshake
//               into a one-entry holding register and shifts them out as
//               8N1 frames (start, 8 data bits LSB first, stop). A byte held
//               when a stop bit ends starts the next frame with no idle gap.
//               Build option: define UART_TX_PARITY_EN to insert a parity
//               bit after data bit 7 (even, or odd when PARITY_ODD = 1).
// Ports       : clk     in  system clock, rising edge
//               rst_n   in  asynchronous active-low reset
//               in_if   --  byte handshake (uart_tx_if.slave)
//               tx      out serial line, idle high, registered
//               busy    out frame in progress or byte held
//               tx_done out one-cycle pulse after each stop bit ends
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = c_default_clk_hz,
    parameter int BAUD       = c_default_baud,
    parameter int PARITY_ODD = 0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    uart_tx_if.slave  in_if,
    output logic      tx,
    output logic      busy,
    output logic      tx_done
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);

    line_state_t r_state;
    line_state_t w_state_next;
    logic [7:0]  r_hold_data;
    logic        r_hold_full;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_tx_done;
    logic        w_load;
    logic        w_accept;
    logic        w_bit_end;
    logic        w_restart;

    // ------------------------------------------------------------------
    // Bit timing: restart on every state change and while idle, so each
    // state begins a fresh bit period.
    // ------------------------------------------------------------------
    assign w_restart = (w_state_next != r_state) || (r_state == ST_IDLE);

    uart_baud_timer #(
        .CLKS_PER_BIT(c_clks_per_bit)
    ) u_baud_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .bit_end (w_bit_end)
    );

    // Ready comes straight from the holding flag; in_valid never feeds it.
    assign w_accept       = in_if.in_valid && !r_hold_full;
    assign in_if.in_ready = !r_hold_full;

    assign tx      = r_tx;
    assign tx_done = r_tx_done;
    assign busy    = (r_state != ST_IDLE) || r_hold_full;

`ifdef UART_TX_PARITY_EN
    // Parity of the byte being shifted, captured when it is loaded.
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^r_hold_data) ^ (PARITY_ODD != 0);
        end
    end
`else
    // Without the parity stage PARITY_ODD selects nothing.
    if (PARITY_ODD != 0) begin : g_parity_odd_unused
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic. The line level is computed from the next state so
    // that the registered tx changes on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;
        w_tx_next      = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_hold_full) begin
                        w_load       = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_next   = r_hold_data;
            w_bit_idx_next = 3'd0;
        end

        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Accept and load are mutually
    // exclusive: accept needs the holding register empty, load needs it
    // full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_tx        <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_tx_done <= (r_state == ST_STOP) && w_bit_end;
            if (w_accept) begin
                r_hold_data <= in_if.in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Two instances share the
//               clock: 12 MHz / 115200 (104 clocks per bit, even parity)
//               and 1000 Hz / 300 (3 clocks per bit, odd parity). Frame
//               expectations include a parity bit when UART_TX_PARITY_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int c_nbits = 11;
`else
    localparam int c_nbits = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    uart_tx_if if_fast ();
    uart_tx_if if_slow ();

    logic tx_fast, busy_fast, done_fast;
    logic tx_slow, busy_slow, done_slow;
    logic m_tx, m_busy, m_ready, m_done;

    uart_tx #(.CLK_HZ(12_000_000), .BAUD(115_200), .PARITY_ODD(0)) u_dut_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_if   (if_fast),
        .tx      (tx_fast),
        .busy    (busy_fast),
        .tx_done (done_fast)
    );

    uart_tx #(.CLK_HZ(1000), .BAUD(300), .PARITY_ODD(1)) u_dut_slow (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_if   (if_slow),
        .tx      (tx_slow),
        .busy    (busy_slow),
        .tx_done (done_slow)
    );

    // Observed instance selected by sel.
    always_comb begin
        m_tx    = tx_fast;
        m_busy  = busy_fast;
        m_ready = if_fast.in_ready;
        m_done  = done_fast;
        if (sel == 1) begin
            m_tx    = tx_slow;
            m_busy  = busy_slow;
            m_ready = if_slow.in_ready;
            m_done  = done_slow;
        end
    end

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        if (s == 0) begin
            if_fast.in_valid = v;
            if_fast.in_data  = d;
        end else begin
            if_slow.in_valid = v;
            if_slow.in_data  = d;
        end
    endtask

    // Walks a frame from sample index 'first' (sample 0 = first negedge with
    // the start bit on the line) and leaves the bench on the sample right
    // after the stop bit, where tx_done must be high.
    task automatic check_frame(input logic [7:0] d, input int first, input int cpb,
                               input logic odd, input logic exp_ready, input string name);
        int bad_tx    = 0;
        int bad_done  = 0;
        int bad_ready = 0;
        int bad_busy  = 0;
        for (int k = first; k < c_nbits * cpb; k++) begin
            int   pos;
            logic e;
            pos = k / cpb;
            if (pos == 0)                e = 1'b0;
            else if (pos <= 8)           e = d[pos-1];
            else if (pos == c_nbits - 1) e = 1'b1;
            else                         e = (^d) ^ odd;
            if (m_tx !== e)            bad_tx++;
            if (m_done !== 1'b0)       bad_done++;
            if (m_ready !== exp_ready) bad_ready++;
            if (m_busy !== 1'b1)       bad_busy++;
            @(negedge clk);
        end
        checks++;
        if (bad_tx != 0) begin
            errors++;
            $display("FAIL %s bits: %0d wrong tx samples, required 0", name, bad_tx);
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL %s early_done: %0d samples with tx_done high, required 0", name, bad_done);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL %s ready: %0d samples with in_ready != %b", name, bad_ready, exp_ready);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL %s busy: %0d samples with busy low, required 0", name, bad_busy);
        end
        checks++;
        if (m_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: tx_done=%b after stop bit, required 1", name, m_done);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        sel = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_fast !== 1'b1 || if_fast.in_ready !== 1'b1 || busy_fast !== 1'b0 || done_fast !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx_fast, if_fast.in_ready, busy_fast, done_fast);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_fast !== 1'b1 || if_fast.in_ready !== 1'b1 || busy_fast !== 1'b0 ||
                tx_slow !== 1'b1 || if_slow.in_ready !== 1'b1 || busy_slow !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad idle cycles, required 0", bad);
        end
    endtask

    task automatic test_single(input int s, input logic [7:0] d, input int cpb,
                               input logic odd, input string name);
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, d);
        @(negedge clk);                      // accepted at the edge just passed
        drive(s, 1'b0, 8'h00);
        checks++;
        if (m_tx !== 1'b1 || m_ready !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: tx=%b ready=%b busy=%b, required 1 0 1", name, m_tx, m_ready, m_busy);
        end
        @(negedge clk);
        checks++;
        if (m_tx !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: tx=%b one cycle after accept, required 0", name, m_tx);
        end
        check_frame(d, 0, cpb, odd, 1'b1, name);
        checks++;
        if (m_tx !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle: tx=%b busy=%b, required 1 0", name, m_tx, m_busy);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: tx_done=%b on second cycle, required 0", name, m_done);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);                      // A5 held; 3C offered while not ready
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold_full: in_ready=%b, required 0", m_ready);
        end
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);                      // A5 loaded, start bit on line
        checks++;
        if (m_tx !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_load: tx=%b ready=%b, required 0 1", m_tx, m_ready);
        end
        @(negedge clk);                      // 3C accepted one cycle after load
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: in_ready=%b, required 0", m_ready);
        end
        drive(0, 1'b0, 8'h00);
        check_frame(8'hA5, 1, 104, 1'b0, 1'b0, "b2b_first");
        checks++;
        if (m_tx !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: tx=%b ready=%b busy=%b, required 0 1 1", m_tx, m_ready, m_busy);
        end
        @(negedge clk);
        check_frame(8'h3C, 1, 104, 1'b0, 1'b1, "b2b_second");
        checks++;
        if (m_tx !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_idle: tx=%b busy=%b, required 1 0", m_tx, m_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        @(negedge clk);                      // sample 0: FF loaded
        drive(0, 1'b1, 8'h12);
        @(negedge clk);                      // sample 1: 12 held
        drive(0, 1'b0, 8'h00);
        checks++;
        if (m_ready !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_held: ready=%b busy=%b, required 0 1", m_ready, m_busy);
        end
        repeat (4 * 104 + 52 - 1) @(negedge clk);   // middle of data bit 3
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tx !== 1'b1 || m_ready !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     m_tx, m_ready, m_busy, m_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_resend: %0d active cycles after reset, required 0", bad);
        end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        test_reset();
        test_single(0, 8'h55, 104, 1'b0, "single_55");
        test_back_to_back();
        test_reset_mid_frame();
        test_single(1, 8'h96, 3, 1'b1, "slow_baud_96");
`ifdef UART_TX_PARITY_EN
        test_single(0, 8'h07, 104, 1'b0, "parity_even_07");
        test_single(1, 8'h07, 3, 1'b1, "parity_odd_07");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx
`default_nettype wire
